// File: rtl/pipe_adder.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// pipe_adder
//
// Pipelined ripple-carry adder/subtractor. The WIDTH-bit operation is cut into
// STAGES = WIDTH/CHUNK slices. Each register stage ripple-adds one CHUNK-bit
// slice and forwards its carry to the next stage. This keeps the long carry
// chain out of any single clock period.
//
// Each stage register holds:
//   - a valid bit;
//   - the result bits produced so far;
//   - the carry out of its slice;
//   - the not-yet-added upper operand bits, pre-shifted so that the next slice
//     always sits at bit 0.
// The final stage also holds the carry into the MSB, which is needed for the
// signed overflow flag.
//
// Flow control is a ready chain that collapses bubbles. A stage loads when it
// is empty or when the stage after it is loading. A full pipeline therefore
// stalls only when every stage is valid and the consumer is not ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears valid and data registers)
//   in_valid   operands present
//   in_ready   pipeline can accept this cycle (combinational)
//   a, b       operands, WIDTH bits
//   cin        carry-in, used in add mode only
//   sub        1: a - b, 0: a + b + cin
//   out_valid  result present
//   out_ready  consumer accepts result
//   sum        result, WIDTH bits, modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1 (in sub mode 1 means no borrow)
//   ovf        signed two's-complement overflow
// -----------------------------------------------------------------------------
module pipe_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / CHUNK;

   generate
      if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
         $fatal(1, "pipe_adder: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Stage registers
   // ---------------------------------------------------------------------
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] carry_q;
   logic [WIDTH-1:0]  res_q   [STAGES];
   logic [WIDTH-1:0]  rem_a_q [STAGES];
   logic [WIDTH-1:0]  rem_b_q [STAGES];
   logic              cmsb_q;

   // Next-state values, computed assuming the stage loads this cycle
   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] carry_d;
   logic [WIDTH-1:0]  res_d   [STAGES];
   logic [WIDTH-1:0]  rem_a_d [STAGES];
   logic [WIDTH-1:0]  rem_b_d [STAGES];
   logic              cmsb_d;

   // What each stage sees on its input side: the conditioned operands for
   // stage 0, or the previous stage's registers for every later stage.
   logic [WIDTH-1:0]  src_a   [STAGES];
   logic [WIDTH-1:0]  src_b   [STAGES];
   logic [WIDTH-1:0]  src_res [STAGES];
   logic [STAGES-1:0] src_c;

   logic [STAGES:0]   load;

   // ---------------------------------------------------------------------
   // Ready chain: load[STAGES] is the consumer. Each stage loads when it is
   // empty or when its successor moves on.
   // ---------------------------------------------------------------------
   always_comb begin : ready_chain
      load         = '0;
      load[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         load[k] = !valid_q[k] | load[k+1];
      end
   end

   assign in_ready = load[0];

   // ---------------------------------------------------------------------
   // Stage input selection and operand conditioning
   // ---------------------------------------------------------------------
   always_comb begin : source_select
      valid_d = '0;
      src_c   = '0;
      for (int k = 0; k < STAGES; k++) begin
         src_a[k]   = '0;
         src_b[k]   = '0;
         src_res[k] = '0;
      end

      // Subtraction is a + ~b + 1; the cin port plays no part in it.
      src_a[0]   = a;
      src_b[0]   = sub ? ~b : b;
      src_c[0]   = sub ? 1'b1 : cin;
      src_res[0] = '0;
      valid_d[0] = in_valid;

      for (int k = 1; k < STAGES; k++) begin
         src_a[k]   = rem_a_q[k-1];
         src_b[k]   = rem_b_q[k-1];
         src_c[k]   = carry_q[k-1];
         src_res[k] = res_q[k-1];
         valid_d[k] = valid_q[k-1];
      end
   end

   // ---------------------------------------------------------------------
   // Per-stage slice adders. Stage k adds the low CHUNK bits of its source
   // operands and places them at result bits [CHUNK*(k+1)-1 : CHUNK*k].
   // ---------------------------------------------------------------------
   always_comb begin : slice_add
      logic c;
      logic x;
      logic y;
      c       = 1'b0;
      x       = 1'b0;
      y       = 1'b0;
      carry_d = '0;
      cmsb_d  = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         res_d[k] = src_res[k];
         c        = src_c[k];
         for (int j = 0; j < CHUNK; j++) begin
            x = src_a[k][j];
            y = src_b[k][j];
            // The carry entering the top bit of the top slice feeds ovf.
            if ((k == STAGES - 1) && (j == CHUNK - 1)) begin
               cmsb_d = c;
            end
            res_d[k][CHUNK*k + j] = x ^ y ^ c;
            c = (x & y) | (x & c) | (y & c);
         end
         carry_d[k] = c;
         // Shift the consumed slice out so the next stage reads bits [CHUNK-1:0].
         rem_a_d[k] = src_a[k] >> CHUNK;
         rem_b_d[k] = src_b[k] >> CHUNK;
      end
   end

   // ---------------------------------------------------------------------
   // Stage registers. A stage that is not loading holds everything. This is
   // what keeps sum/cout/ovf stable while the consumer stalls.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         carry_q <= '0;
         cmsb_q  <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            res_q[k]   <= '0;
            rem_a_q[k] <= '0;
            rem_b_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               valid_q[k] <= valid_d[k];
               carry_q[k] <= carry_d[k];
               res_q[k]   <= res_d[k];
               rem_a_q[k] <= rem_a_d[k];
               rem_b_q[k] <= rem_b_d[k];
            end
         end
         if (load[STAGES-1]) begin
            cmsb_q <= cmsb_d;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs come straight from the final stage
   // ---------------------------------------------------------------------
   assign out_valid = valid_q[STAGES-1];
   assign sum       = res_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign ovf       = cmsb_q ^ carry_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_pipe_adder
//
// Self-checking bench for pipe_adder with WIDTH=16 and CHUNK=4 (4 stages).
// It runs directed vectors from a table, measuring latency and checking each
// result. It then runs streamed random operations with a fixed stall window
// and with random back-pressure, scored against an arithmetic reference
// model. Last, it drops reset with operations in flight.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int STAGES = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int checks = 0;
   int errors = 0;

   // Expected results, oldest first, packed as {sum, cout, ovf}
   logic [17:0] exp_q[$];

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic        vcin;
      logic        vsub;
      logic [15:0] es;
      logic        eco;
      logic        eov;
   } vec_t;

   vec_t vecs[8];

   pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Reference model in plain integer arithmetic. Overflow is defined here as
   // the exact signed result falling outside the 16-bit range.
   function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mcin, input logic msub);
      logic [15:0] bb;
      int unsigned utot;
      int          stot;
      int          c;
      logic [15:0] s;
      logic        co;
      logic        ov;
      bb   = msub ? ~mb : mb;
      c    = msub ? 1 : int'(mcin);
      utot = int'(ma) + int'(bb) + c;
      stot = int'($signed(ma)) + int'($signed(bb)) + c;
      s    = utot[15:0];
      co   = utot[16];
      ov   = (stot > 32767) || (stot < -32768);
      return {s, co, ov};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // A single operation on an idle pipeline, with its latency measured in edges
   task automatic run_one(input int idx);
      int edges;
      @(negedge clk);
      a         = vecs[idx].va;
      b         = vecs[idx].vb;
      cin       = vecs[idx].vcin;
      sub       = vecs[idx].vsub;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      edges    = 1;
      while (!out_valid && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk($sformatf("vec%0d_latency", idx), 32'(edges), 32'(STAGES));
      chk($sformatf("vec%0d_result", idx), 32'({sum, cout, ovf}),
          32'({vecs[idx].es, vecs[idx].eco, vecs[idx].eov}));
      $display("vec%0d a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d edges=%0d",
               idx, vecs[idx].va, vecs[idx].vb, vecs[idx].vcin, vecs[idx].vsub,
               sum, cout, ovf, edges);
      @(posedge clk);
   endtask

   // Streams nops random operations. rand_mode=0 drives in_valid whenever an
   // operation is pending and holds out_ready low for cycles stall_lo..stall_hi.
   // rand_mode=1 randomises both in_valid and out_ready.
   task automatic run_stream(input int nops, input bit rand_mode, input int stall_lo,
                             input int stall_hi);
      int          sent     = 0;
      int          got      = 0;
      int          cyc      = 0;
      int          inflight = 0;
      bit          have     = 0;
      bit          prev_stall = 0;
      bit          saw_full = 0;
      logic [17:0] prev_out = '0;
      logic [17:0] exp;
      logic [15:0] ca = '0;
      logic [15:0] cb = '0;
      logic        ccin = 1'b0;
      logic        csub = 1'b0;
      while (got < nops && cyc < 2000) begin
         @(negedge clk);
         if (!have && sent < nops) begin
            ca   = 16'($urandom);
            cb   = 16'($urandom);
            ccin = 1'($urandom);
            csub = 1'($urandom);
            have = 1;
         end
         a   = ca;
         b   = cb;
         cin = ccin;
         sub = csub;
         if (rand_mode) begin
            in_valid  = have && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
         end else begin
            in_valid  = have;
            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
         end
         #1;
         // The pipeline refuses input only when every stage holds an
         // operation and the consumer is stalled.
         chk($sformatf("stream_in_ready_c%0d", cyc), 32'(in_ready),
             32'(!(inflight == STAGES && !out_ready)));
         if (!in_ready) saw_full = 1;
         if (prev_stall) begin
            chk($sformatf("stall_valid_c%0d", cyc), 32'(out_valid), 32'd1);
            chk($sformatf("stall_hold_c%0d", cyc), 32'({sum, cout, ovf}), 32'(prev_out));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("spurious_out_c%0d", cyc), 32'd1, 32'd0);
            end else begin
               exp = exp_q.pop_front();
               chk($sformatf("stream_result_%0d", got), 32'({sum, cout, ovf}), 32'(exp));
               inflight--;
            end
            $display("out %0d cyc=%0d sum=%h cout=%0d ovf=%0d", got, cyc, sum, cout, ovf);
            got++;
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {sum, cout, ovf};
         if (in_valid && in_ready) begin
            exp_q.push_back(model(ca, cb, ccin, csub));
            $display("in  %0d cyc=%0d a=%h b=%h cin=%0d sub=%0d", sent, cyc, ca, cb, ccin, csub);
            sent++;
            inflight++;
            have = 0;
         end
         cyc++;
      end
      chk("stream_count", 32'(got), 32'(nops));
      if (!rand_mode) chk("stream_saw_full", 32'(saw_full), 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0};
      vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_sum", 32'(sum), 32'h0);
      chk("reset_cout", 32'(cout), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors
      for (int i = 0; i < 8; i++) begin
         run_one(i);
      end

      // Back-to-back stream with a stall window, then random back-pressure
      run_stream(10, 1'b0, 3, 7);
      run_stream(40, 1'b1, 0, 0);

      // Reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a         = 16'($urandom);
         b         = 16'($urandom);
         cin       = 1'($urandom);
         sub       = 1'b0;
         in_valid  = 1'b1;
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", 32'(out_valid), 32'd0);
      chk("midreset_sum", 32'(sum), 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("postreset_quiet_%0d", i), 32'(out_valid), 32'd0);
      end
      run_one(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parameterised, pipelined ripple-carry adder/subtractor. It is the sequential successor of the team's 4-bit combinational full-adder chain.
- The WIDTH-bit operation is split into STAGES = WIDTH/CHUNK slices of CHUNK bits. Each slice is ripple-added in its own register stage, with the carry passed stage to stage.
- Valid/ready handshake on both sides, per-stage bubble collapsing, and full throughput of one operation per cycle.
- Sits between operand sources and arithmetic consumers in the datapath. It breaks the long carry chain for timing.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits added per pipeline stage. WIDTH % CHUNK must be 0; otherwise an elaboration-time error ($error / $fatal).
- STAGES, WIDTH/CHUNK, derived (localparam): pipeline depth.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  pipeline can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  1 = A - B, 0 = A + B + cin
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (in sub mode, 1 = no borrow)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear and all data registers clear. Outputs are then out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once rst_n is high.
- Reset mid-operation drops every in-flight transaction; nothing is emitted after release.
- Operand conditioning at entry:
  - sub=1: B' = ~b and carry-in = 1; the cin port is ignored.
  - sub=0: B' = b and carry-in = cin.
- Stage k (0..STAGES-1) register contents:
  - valid bit;
  - result bits [CHUNK*(k+1)-1:0];
  - carry out of slice k;
  - unprocessed upper bits of A and B' (may be trimmed per stage);
  - carry into the MSB, held in the final stage only.
- Stage k loads slice k of A/B' plus the carry from stage k-1. Stage 0 loads directly from the inputs.
- Flow control:
  - load[STAGES] = out_ready
  - load[k] = !valid[k] | load[k+1]
  - in_ready = load[0], combinational
  - A stage that is not loading holds all its contents.
  - On a load, stage k's valid bit takes valid[k-1]; stage 0 takes in_valid.
- Handshake rules:
  - Input transfer happens on the edge where in_valid & in_ready = 1.
  - Output transfer happens on the edge where out_valid & out_ready = 1.
  - sum, cout and ovf stay stable while out_valid=1 and out_ready=0.
- Latency: an operation accepted at edge E appears on out_valid/sum after edge E+STAGES-1, i.e. STAGES edges counting the accepting edge. This holds only when no downstream stall occurs.
- Throughput: with out_ready held at 1, one result per cycle and in_ready stays 1.
- Ordering: results leave in acceptance order; no loss or duplication under any out_ready pattern.
- Full pipeline (all STAGES valid) with out_ready=0 gives in_ready=0. When out_ready rises, in_ready=1 in the same cycle.
- Empty pipeline: out_valid=0; sum, cout and ovf hold their last values and are don't-care.
- Output flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR cout.
- Arithmetic is modulo 2^WIDTH, no saturation.
- STAGES=1 degenerates to a single registered adder with the same handshake.

Test Plan (WIDTH=16, CHUNK=4):
1. Assert rst_n=0 for 3 cycles -> out_valid=0, sum=0x0000, cout=0, ovf=0; after release, in_ready=1.
2. Add a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> sum=0x0100, cout=0, ovf=0. Result appears exactly 4 edges after acceptance, counting the accepting edge.
3. Add 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0. Then add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. Then add 0x0003+0x0005 with cin=1 -> sum=0x0009.
4. Subtract 0x0005-0x0007 with sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored). Subtract 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
5. Stream 10 back-to-back random ops with in_valid=1, holding out_ready=0 for cycles 3-7:
   - in_ready falls once 4 ops are held;
   - outputs are stable while stalled;
   - all 10 results match the reference model, in order.
6. Drop rst_n with 3 ops in flight, then release -> out_valid=0 immediately and stays 0. A new op accepted afterwards returns its correct result after 4 edges.
